// File: rtl/multi_frame_receptor.sv
// multi_frame_receptor
// Terminates NUM_PORTS independent 16-bit AXI-Stream Ethernet ingress ports. Each port checks
// the destination MAC, sums the payload, counts frames and drops, and enforces a programmable
// inter-frame gap. All per-port state is visible through one 8-bit Avalon-MM slave.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   writedata/write      Avalon write data and strobe
//   chipselect           Avalon chip select
//   address              [7:4] port index, [3:0] register offset
//   read/readdata        Avalon read strobe; read data valid the following cycle, else 0
//   ingress_port_tdata   16 bits per port, port p at [16p+15:16p], first wire byte in [15:8]
//   ingress_port_tvalid  per-port valid
//   ingress_port_tready  per-port ready (low only during the inter-frame gap)
//   ingress_port_tlast   per-port end of frame
//   frame_done           per-port one-cycle pulse after a frame's results commit
//
// Register map per port: 0-5 dst MAC (RW), 6 IFG (RW), 7 status (R),
//   8-11 checksum LSB first (R), 12-13 frame_count (R, write clears both counters),
//   14-15 drop_count (R).
module multi_frame_receptor #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned CSUM_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                writedata,
    input  logic                      write,
    input  logic                      chipselect,
    input  logic [7:0]                address,
    input  logic                      read,
    output logic [7:0]                readdata,
    input  logic [16*NUM_PORTS-1:0]   ingress_port_tdata,
    input  logic [NUM_PORTS-1:0]      ingress_port_tvalid,
    output logic [NUM_PORTS-1:0]      ingress_port_tready,
    input  logic [NUM_PORTS-1:0]      ingress_port_tlast,
    output logic [NUM_PORTS-1:0]      frame_done
);

    typedef enum logic [1:0] {StIdle, StHdr, StPayload, StGap} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [3:0] port_idx;
    logic [3:0] reg_off;
    logic       host_wr;
    logic [7:0] port_rdata [NUM_PORTS];
    logic [7:0] rd_val;

    assign port_idx = address[7:4];
    assign reg_off  = address[3:0];
    assign host_wr  = chipselect & write;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [3:0] PortIdx = 4'(p);

        state_e                state_q, state_d;
        logic [2:0]            beat_q, beat_d;
        logic                  match_q, match_d;
        logic [CSUM_WIDTH-1:0] acc_q, acc_d;
        logic [7:0]            gap_q, gap_d;

        logic [7:0]            mac_q [6];
        logic [7:0]            ifg_q;
        logic [2:0]            status_q;
        logic [CSUM_WIDTH-1:0] csum_q;
        logic [CNT_WIDTH-1:0]  fcnt_q;
        logic [CNT_WIDTH-1:0]  dcnt_q;
        logic                  done_q;

        logic                  sel_wr;
        logic                  cnt_clr;
        logic [15:0]           tdata;
        logic                  tready;
        logic                  accept;
        logic [2:0]            hdr_idx;
        logic [15:0]           mac_word;
        logic                  dst_miss;
        logic [CSUM_WIDTH-1:0] sum;
        logic                  commit_ok;
        logic                  commit_runt;
        logic [31:0]           csum_ext;
        logic [15:0]           fcnt_ext;
        logic [15:0]           dcnt_ext;

        assign sel_wr  = host_wr && (port_idx == PortIdx);
        assign cnt_clr = sel_wr && (reg_off == 4'd12);
        assign tdata   = ingress_port_tdata[16*p +: 16];
        assign tready  = (state_q != StGap);
        assign accept  = ingress_port_tvalid[p] & tready;
        // The beat accepted in IDLE is header beat 0.
        assign hdr_idx = (state_q == StIdle) ? 3'd0 : beat_q;
        assign sum     = acc_q + CSUM_WIDTH'(tdata);

        assign ingress_port_tready[p] = tready;
        assign frame_done[p]          = done_q;

        always_comb begin
            mac_word = '0;
            case (hdr_idx)
                3'd0:    mac_word = {mac_q[0], mac_q[1]};
                3'd1:    mac_word = {mac_q[2], mac_q[3]};
                3'd2:    mac_word = {mac_q[4], mac_q[5]};
                default: mac_word = '0;
            endcase
        end

        assign dst_miss = (hdr_idx <= 3'd2) && (tdata != mac_word);

        always_comb begin
            state_d     = state_q;
            beat_d      = beat_q;
            match_d     = match_q;
            acc_d       = acc_q;
            gap_d       = gap_q;
            commit_ok   = 1'b0;
            commit_runt = 1'b0;
            unique case (state_q)
                StIdle, StHdr: begin
                    if (accept) begin
                        match_d = ((state_q == StIdle) || match_q) && !dst_miss;
                        if (ingress_port_tlast[p]) begin
                            commit_runt = 1'b1;
                        end else if (hdr_idx == 3'd6) begin
                            state_d = StPayload;
                            acc_d   = '0;
                        end else begin
                            state_d = StHdr;
                            beat_d  = hdr_idx + 3'd1;
                        end
                    end
                end
                StPayload: begin
                    if (accept) begin
                        acc_d = sum;
                        if (ingress_port_tlast[p]) begin
                            commit_ok = 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (gap_q <= 8'd1) begin
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (commit_ok || commit_runt) begin
                if (ifg_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StGap;
                    gap_d   = ifg_q;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= StIdle;
                beat_q   <= '0;
                match_q  <= 1'b0;
                acc_q    <= '0;
                gap_q    <= '0;
                for (int i = 0; i < 6; i++) begin
                    mac_q[i] <= '0;
                end
                ifg_q    <= '0;
                status_q <= '0;
                csum_q   <= '0;
                fcnt_q   <= '0;
                dcnt_q   <= '0;
                done_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                beat_q  <= beat_d;
                match_q <= match_d;
                acc_q   <= acc_d;
                gap_q   <= gap_d;
                done_q  <= commit_ok | commit_runt;

                if (sel_wr) begin
                    if (reg_off < 4'd6) begin
                        mac_q[reg_off[2:0]] <= writedata;
                    end else if (reg_off == 4'd6) begin
                        ifg_q <= writedata;
                    end
                end

                if (commit_ok) begin
                    csum_q   <= sum;
                    status_q <= {1'b0, 1'b1, match_q};
                end else if (commit_runt) begin
                    status_q <= 3'b110;
                end

                // A host clear in the commit cycle overrides that commit's increments.
                if (cnt_clr) begin
                    fcnt_q <= '0;
                    dcnt_q <= '0;
                end else begin
                    if (commit_ok && fcnt_q != CntMax) begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                    if ((commit_runt || (commit_ok && !match_q)) && dcnt_q != CntMax) begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
            end
        end

        assign csum_ext = 32'(csum_q);
        assign fcnt_ext = 16'(fcnt_q);
        assign dcnt_ext = 16'(dcnt_q);

        always_comb begin
            port_rdata[p] = '0;
            case (reg_off)
                4'd0:  port_rdata[p] = mac_q[0];
                4'd1:  port_rdata[p] = mac_q[1];
                4'd2:  port_rdata[p] = mac_q[2];
                4'd3:  port_rdata[p] = mac_q[3];
                4'd4:  port_rdata[p] = mac_q[4];
                4'd5:  port_rdata[p] = mac_q[5];
                4'd6:  port_rdata[p] = ifg_q;
                4'd7:  port_rdata[p] = {5'b0, status_q};
                4'd8:  port_rdata[p] = csum_ext[7:0];
                4'd9:  port_rdata[p] = csum_ext[15:8];
                4'd10: port_rdata[p] = csum_ext[23:16];
                4'd11: port_rdata[p] = csum_ext[31:24];
                4'd12: port_rdata[p] = fcnt_ext[7:0];
                4'd13: port_rdata[p] = fcnt_ext[15:8];
                4'd14: port_rdata[p] = dcnt_ext[7:0];
                4'd15: port_rdata[p] = dcnt_ext[15:8];
                default: port_rdata[p] = '0;
            endcase
        end
    end

    // Out-of-range port indices match no port and read as zero.
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_idx == 4'(p)) begin
                rd_val = port_rdata[p];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= (chipselect & read) ? rd_val : 8'd0;
        end
    end

endmodule

// File: tb/tb_multi_frame_receptor.sv
// Directed testbench for multi_frame_receptor (4 ports, 32-bit checksum, 8-bit counters).
module tb_multi_frame_receptor;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      writedata;
    logic            write;
    logic            chipselect;
    logic [7:0]      address;
    logic            read;
    logic [7:0]      readdata;
    logic [16*NP-1:0] tdata;
    logic [NP-1:0]   tvalid;
    logic [NP-1:0]   tready;
    logic [NP-1:0]   tlast;
    logic [NP-1:0]   frame_done;

    always #5 clk = ~clk;

    multi_frame_receptor #(
        .NUM_PORTS (NP),
        .CSUM_WIDTH(32),
        .CNT_WIDTH (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .writedata          (writedata),
        .write              (write),
        .chipselect         (chipselect),
        .address            (address),
        .read               (read),
        .readdata           (readdata),
        .ingress_port_tdata (tdata),
        .ingress_port_tvalid(tvalid),
        .ingress_port_tready(tready),
        .ingress_port_tlast (tlast),
        .frame_done         (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt [NP] = '{default: 0};
    logic [15:0] fr [NP][16];

    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (frame_done[p]) done_cnt[p] <= done_cnt[p] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input int p, input int off, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; writedata = d;
        address = {4'(p), 4'(off)};
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input int p, input int off, output logic [7:0] d);
        chipselect = 1'b1; read = 1'b1;
        address = {4'(p), 4'(off)};
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Little-endian multi-byte register read.
    task automatic rd_word(input int p, input int base, input int nbytes, output logic [31:0] v);
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < nbytes; i++) begin
            bus_rd(p, base + i, b);
            v[8*i +: 8] = b;
        end
    endtask

    task automatic set_mac(input int p, input logic [47:0] mac);
        for (int i = 0; i < 6; i++) bus_wr(p, i, mac[47 - 8*i -: 8]);
    endtask

    task automatic set_frame(input int p, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] y0,
                             input logic [15:0] y1);
        fr[p][0] = d0; fr[p][1] = d1; fr[p][2] = d2;
        fr[p][3] = 16'hA0A0; fr[p][4] = 16'hB0B0; fr[p][5] = 16'hC0C0; fr[p][6] = 16'h0800;
        fr[p][7] = y0; fr[p][8] = y1;
    endtask

    // Drive the ports in mask in lockstep; clr_port >= 0 issues a counter clear on that port
    // in the same cycle as the final beat.
    task automatic send(input logic [NP-1:0] mask, input int len, input int clr_port);
        int guard;
        for (int i = 0; i < len; i++) begin
            for (int p = 0; p < NP; p++) if (mask[p]) tdata[16*p +: 16] = fr[p][i];
            tvalid = mask;
            tlast  = (i == len - 1) ? mask : '0;
            guard  = 0;
            while ((tready & mask) != mask && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) check("ready_timeout", 32'(tready & mask), 32'(mask));
            if (i == len - 1 && clr_port >= 0) begin
                chipselect = 1'b1; write = 1'b1; writedata = 8'h00;
                address = {4'(clr_port), 4'd12};
            end
            tick();
            chipselect = 1'b0; write = 1'b0;
        end
        tvalid = '0; tlast = '0;
    endtask

    logic [31:0] v;
    logic [7:0]  b;
    int          snap [NP];
    int          lowc;

    initial begin
        reset = 1'b1; writedata = '0; write = 1'b0; chipselect = 1'b0; address = '0;
        read = 1'b0; tdata = '0; tvalid = '0; tlast = '0;
        #1;
        check("rst_readdata", 32'(readdata), 0);
        check("rst_tready", 32'(tready), 32'hF);
        check("rst_done", 32'(frame_done), 0);
        #22 reset = 1'b0;
        tick();

        // T1: matching frame on port 0
        set_mac(0, 48'h01_02_03_04_05_06);
        bus_rd(0, 2, b);
        check("mac_rw", 32'(b), 32'h03);
        tick();
        check("readdata_idle", 32'(readdata), 0);
        snap[0] = done_cnt[0];
        set_frame(0, 16'h0102, 16'h0304, 16'h0506, 16'hFFFF, 16'h0001);
        send(4'b0001, 9, -1);
        rd_word(0, 7, 1, v);  check("t1_status", v, 32'h03);
        rd_word(0, 8, 4, v);  check("t1_csum", v, 32'h0001_0000);
        rd_word(0, 12, 2, v); check("t1_fcnt", v, 1);
        rd_word(0, 14, 2, v); check("t1_dcnt", v, 0);
        check("t1_done", 32'(done_cnt[0] - snap[0]), 1);

        // T2: destination miss on beat 1
        bus_wr(0, 12, 8'h00);
        set_frame(0, 16'h0102, 16'h0305, 16'h0506, 16'hFFFF, 16'h0001);
        send(4'b0001, 9, -1);
        rd_word(0, 7, 1, v);  check("t2_status", v, 32'h02);
        rd_word(0, 12, 2, v); check("t2_fcnt", v, 1);
        rd_word(0, 14, 2, v); check("t2_dcnt", v, 1);

        // T3: IFG=5 on port 2, back-to-back frames
        bus_wr(2, 6, 8'd5);
        set_frame(2, 16'h0102, 16'h0304, 16'h0506, 16'hFFFF, 16'h0001);
        send(4'b0100, 9, -1);
        lowc = 0;
        while (!tready[2] && lowc < 20) begin
            lowc++;
            tick();
        end
        check("t3_gap_len", 32'(lowc), 5);
        set_frame(2, 16'h0102, 16'h0304, 16'h0506, 16'h1234, 16'h0002);
        send(4'b0100, 9, -1);
        rd_word(2, 8, 4, v);  check("t3_csum", v, 32'h1236);
        rd_word(2, 12, 2, v); check("t3_fcnt", v, 2);
        rd_word(2, 14, 2, v); check("t3_dcnt", v, 2);
        rd_word(2, 7, 1, v);  check("t3_status", v, 32'h02);

        // T4: 5-beat runt on port 0
        snap[0] = done_cnt[0];
        fr[0][3] = 16'h1111; fr[0][4] = 16'h2222;
        fr[0][0] = 16'h0102; fr[0][1] = 16'h0304; fr[0][2] = 16'h0506;
        send(4'b0001, 5, -1);
        rd_word(0, 7, 1, v);  check("t4_status", v, 32'h06);
        rd_word(0, 14, 2, v); check("t4_dcnt", v, 2);
        rd_word(0, 12, 2, v); check("t4_fcnt", v, 1);
        rd_word(0, 8, 4, v);  check("t4_csum", v, 32'h0001_0000);
        check("t4_done", 32'(done_cnt[0] - snap[0]), 1);

        // T5: counter saturation and clear coincident with commit on port 1
        set_mac(1, 48'h01_02_03_04_05_06);
        snap[1] = done_cnt[1];
        set_frame(1, 16'h0102, 16'h0304, 16'h0506, 16'h0010, 16'h0020);
        for (int k = 0; k < 260; k++) send(4'b0010, 9, -1);
        rd_word(1, 12, 2, v); check("t5_fcnt_sat", v, 32'hFF);
        rd_word(1, 14, 2, v); check("t5_dcnt", v, 0);
        check("t5_done", 32'(done_cnt[1] - snap[1]), 260);
        send(4'b0010, 9, 1);
        rd_word(1, 12, 2, v); check("t5_clr_fcnt", v, 0);
        rd_word(1, 14, 2, v); check("t5_clr_dcnt", v, 0);
        rd_word(1, 8, 4, v);  check("t5_csum", v, 32'h30);

        // Out-of-range port
        bus_wr(5, 6, 8'h55);
        bus_rd(5, 6, b);  check("oor_ifg", 32'(b), 0);
        bus_rd(15, 0, b); check("oor_mac", 32'(b), 0);

        // T6: simultaneous commits on all ports
        for (int p = 0; p < NP; p++) begin
            bus_wr(p, 12, 8'h00);
            snap[p] = done_cnt[p];
        end
        for (int p = 0; p < 3; p++)
            set_frame(p, 16'h0102, 16'h0304, 16'h0506, 16'(16'h0100 * (p + 1)), 16'h0003);
        set_frame(3, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0003);
        send(4'b1111, 9, -1);
        for (int p = 0; p < NP; p++) begin
            rd_word(p, 8, 4, v);  check($sformatf("t6_csum%0d", p), v, 32'(256 * (p + 1) + 3));
            rd_word(p, 12, 2, v); check($sformatf("t6_fcnt%0d", p), v, 1);
            rd_word(p, 14, 2, v); check($sformatf("t6_dcnt%0d", p), v, (p == 2) ? 1 : 0);
            rd_word(p, 7, 1, v);  check($sformatf("t6_stat%0d", p), v, (p == 2) ? 2 : 3);
            check($sformatf("t6_done%0d", p), 32'(done_cnt[p] - snap[p]), 1);
        end

        // Asynchronous reset in the middle of a frame on port 0
        send(4'b0001, 3, -1);
        tvalid = 4'b0001; tdata[15:0] = 16'hA0A0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tready", 32'(tready), 32'hF);
        check("mid_rst_done", 32'(frame_done), 0);
        check("mid_rst_rdata", 32'(readdata), 0);
        tvalid = '0;
        tick();
        #3 reset = 1'b0;
        tick();
        rd_word(0, 12, 2, v); check("post_rst_fcnt", v, 0);
        rd_word(0, 14, 2, v); check("post_rst_dcnt", v, 0);
        rd_word(0, 7, 1, v);  check("post_rst_status", v, 0);
        rd_word(0, 0, 1, v);  check("post_rst_mac", v, 0);
        rd_word(2, 6, 1, v);  check("post_rst_ifg", v, 0);
        rd_word(1, 8, 4, v);  check("post_rst_csum", v, 0);
        set_frame(0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 16'h0022);
        send(4'b0001, 9, -1);
        rd_word(0, 8, 4, v);  check("post_rst_frame_csum", v, 32'h33);
        rd_word(0, 7, 1, v);  check("post_rst_frame_status", v, 32'h03);
        rd_word(0, 12, 2, v); check("post_rst_frame_fcnt", v, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
